saber_matvec_sched: RTL and testbench
=====================================

Name: saber_matvec_sched

Overview:
- Sequences one `poly_mul256_parallel_in2` instance to compute a Saber matrix-vector product, b_i = sum_j A_ij * s_j (or the transpose A_ji), for i, j in 0..L-1.
- Generates the multiplier's restart, accumulator-clear and read controls.
- Supplies BRAM base addresses; the multiplier's relative addresses are added to these externally.
- Streams each accumulated result row to a result BRAM, 4 coefficients per beat.

Parameters:
- L, 3, module rank: 2 = LightSaber, 3 = Saber, 4 = FireSaber.
- AW, 10, width of every BRAM word address.
- POL_WORDS, 52, 64-bit words per 13-bit packed polynomial.
- SEC_WORDS, 16, 64-bit words per 4-bit packed secret polynomial.
- READ_BEATS, 64, accumulator shifts per result polynomial (3328/52).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle start pulse; accepted only in IDLE
- transpose  in  1  use A_ji instead of A_ij; sampled on accepted start
- coeff4x  in  1  polynomial words are 4x uint16; sampled on accepted start
- a_base  in  AW  word address of A_00
- s_base  in  AW  word address of s_0
- r_base  in  AW  word address of result row 0
- mul_rst  out  1  synchronous restart of multiplier
- mul_acc_clear  out  1  multiplier accumulator clear
- mul_read  out  1  multiplier accumulator shift-out
- mul_coeff4x  out  1  latched coeff4x, drives pol_load_coeff4x
- mul_done  in  1  multiplier pol_mul_done
- pol_addr_base  out  AW  base for the multiplier polynomial address
- sec_addr_base  out  AW  base for the multiplier secret address
- res_we  out  1  result write enable
- res_addr  out  AW  result write address
- busy  out  1  high from accepted start until the DONE cycle, inclusive
- done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE; i, j, beat counters = 0; mul_rst = 1 (the multiplier is held in reset while IDLE). All other outputs are 0.
- Reset mid-operation: abandons the run at the next edge; all outputs return to reset values; no further res_we.
- FSM, all outputs registered:
  - IDLE:
    - mul_rst=1.
    - On start: latch transpose, coeff4x and the bases; i=j=0; go to CLR.
  - CLR (1 cycle):
    - mul_rst=1, mul_acc_clear=1.
    - Load pol_addr_base = a_base + idx*POL_WORDS, with idx = i*L+j (or j*L+i if transpose).
    - Load sec_addr_base = s_base + j*SEC_WORDS.
    - Go to RUN.
  - RUN:
    - mul_rst=0.
    - mul_done is ignored in the first RUN cycle, because the multiplier is still leaving its state 0.
    - On mul_done: if j<L-1, increment j and go to MRST; else go to READ.
  - MRST (1 cycle):
    - mul_rst=1, mul_acc_clear=0, so the accumulator keeps the partial sum.
    - Bases are updated for the new j.
    - Go to RUN.
  - READ (READ_BEATS cycles):
    - mul_read=1 and res_we=1 in the same cycle; the write data is the multiplier's combinational coeff4x_out.
    - res_addr = r_base + i*READ_BEATS + beat, with beat running 0..63.
    - After beat 63: if i<L-1, increment i, set j=0 and go to CLR; else go to DONE.
  - DONE (1 cycle): done=1, mul_rst=1; go to IDLE.
- Address arithmetic:
  - Computed incrementally with adders only: no multipliers.
  - Modulo 2^AW; wrap-around is silent and is the caller's responsibility.
- Simultaneous start and rst: rst wins.
- start while busy: ignored, with no effect on latched inputs.
- mul_done is never sampled outside RUN.
- mul_acc_clear and mul_read are never high in the same cycle.
- mul_read is never high unless the multiplier is in its done state.
- Throughput per row: 1 (CLR) + L*(T_mul+1) + (L-1) (MRST) + 64 (READ) cycles, where T_mul is the cycle count from mul_rst deassert to mul_done.

Decomposition:
- Package saber_sched_pkg holds:
  - the state enum (IDLE, CLR, RUN, MRST, READ, DONE);
  - POL_WORDS, SEC_WORDS, READ_BEATS;
  - L values per Saber variant.
- One sub-module, saber_matvec_addr_gen: an incremental base-address generator for A (normal and transposed stride), s and r. It takes step/row/reset strobes from the FSM.

Test Plan:
- L=3, transpose=0, a_base=0, s_base=0x200, r_base=0x300. Behavioural multiplier with T_mul=40.
  - -> pol_addr_base sequence 0, 52, 104 for row 0; 156 for row 1 col 0.
  - -> sec_addr_base sequence 0x200, 0x210, 0x220.
  - -> 192 res_we beats at 0x300..0x3BF.
  - -> done exactly once, 1+3*41+2+64 = 190 cycles per row after start.
- transpose=1, L=3, a_base=0.
  - -> row 0 pol_addr_base sequence 0, 156, 312.
  - -> row 1 pol_addr_base sequence 52, 208, 364.
- Full numeric check: random A and s, real multiplier instance, coeff4x=0.
  - -> each written row equals sum_j A_ij*s_j mod (x^256+1, 2^13).
  - Also checks that mul_acc_clear occurs once per row only.
- Reset asserted during READ beat 20.
  - -> res_we low from the next cycle; busy=0; mul_rst=1.
  - -> a new start afterwards produces a correct full run.
- start pulsed during RUN with different transpose/bases.
  - -> ignored; addresses follow the original run.
- mul_done held high continuously (stale).
  - -> first RUN cycle ignores it; every RUN lasts at least 2 cycles; no missed MRST.

Source files
------------

// File: rtl/saber_sched_pkg.sv
// Shared types and constants for the Saber matrix-vector scheduler.
// Holds the FSM state encoding, the default BRAM layout strides and the per-variant module ranks.
package saber_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    MRST = 3'd3,
    READ = 3'd4,
    DONE = 3'd5
  } sched_state_t;

  // 64-bit words per 13-bit packed polynomial and per 4-bit packed secret.
  localparam int DEF_POL_WORDS  = 52;
  localparam int DEF_SEC_WORDS  = 16;
  // Accumulator shift-outs per result polynomial (4 coefficients each).
  localparam int DEF_READ_BEATS = 64;

  localparam int L_LIGHTSABER = 2;
  localparam int L_SABER      = 3;
  localparam int L_FIRESABER  = 4;

endpackage

// File: rtl/saber_matvec_addr_gen.sv
// Incremental base-address generator for A (row-major or transposed walk), s and the result rows.
// Only adders and constant strides are used; every address wraps silently modulo 2^AW.
module saber_matvec_addr_gen
  import saber_sched_pkg::*;
#(
  parameter int L     = L_SABER,
  parameter int AW    = 10,
  parameter int POL_W = DEF_POL_WORDS,
  parameter int SEC_W = DEF_SEC_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          transpose,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] s_base,
  input  logic [AW-1:0] r_base,
  input  logic          col_step,
  input  logic          row_step,
  input  logic          res_step,
  output logic [AW-1:0] pol_addr,
  output logic [AW-1:0] sec_addr,
  output logic [AW-1:0] res_addr
);

  localparam logic [AW-1:0] ONE_POL  = AW'(POL_W);
  localparam logic [AW-1:0] L_POLS   = AW'(L * POL_W);
  localparam logic [AW-1:0] SEC_STEP = AW'(SEC_W);
  localparam logic [AW-1:0] RES_STEP = AW'(1);

  logic          tr_q;
  logic [AW-1:0] s_base_q;
  logic [AW-1:0] row_addr;
  logic [AW-1:0] col_stride;
  logic [AW-1:0] row_stride;

  // Transposed walk swaps the roles of the column and row strides.
  assign col_stride = tr_q ? L_POLS : ONE_POL;
  assign row_stride = tr_q ? ONE_POL : L_POLS;

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_q     <= 1'b0;
      s_base_q <= '0;
      row_addr <= '0;
      pol_addr <= '0;
      sec_addr <= '0;
      res_addr <= '0;
    end else if (init) begin
      tr_q     <= transpose;
      s_base_q <= s_base;
      row_addr <= a_base;
      pol_addr <= a_base;
      sec_addr <= s_base;
      res_addr <= r_base;
    end else begin
      if (row_step) begin
        row_addr <= row_addr + row_stride;
        pol_addr <= row_addr + row_stride;
        sec_addr <= s_base_q;
      end else if (col_step) begin
        pol_addr <= pol_addr + col_stride;
        sec_addr <= sec_addr + SEC_STEP;
      end
      // Result rows are contiguous, so one running pointer covers every row.
      if (res_step) begin
        res_addr <= res_addr + RES_STEP;
      end
    end
  end

endmodule

// File: rtl/saber_matvec_sched.sv
// Sequences one polynomial multiplier through b_i = sum_j A_ij*s_j (or A_ji) and streams each row out.
// All outputs are registered; mul_done is only honoured from the second RUN cycle onward.
module saber_matvec_sched
  import saber_sched_pkg::*;
#(
  parameter int L          = L_SABER,
  parameter int AW         = 10,
  parameter int POL_WORDS  = DEF_POL_WORDS,
  parameter int SEC_WORDS  = DEF_SEC_WORDS,
  parameter int READ_BEATS = DEF_READ_BEATS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          transpose,
  input  logic          coeff4x,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] s_base,
  input  logic [AW-1:0] r_base,
  output logic          mul_rst,
  output logic          mul_acc_clear,
  output logic          mul_read,
  output logic          mul_coeff4x,
  input  logic          mul_done,
  output logic [AW-1:0] pol_addr_base,
  output logic [AW-1:0] sec_addr_base,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic          busy,
  output logic          done
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int BW = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(L - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(READ_BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  sched_state_t  state, state_nxt;
  logic [IW-1:0] i_q, i_nxt;
  logic [IW-1:0] j_q, j_nxt;
  logic [BW-1:0] beat_q, beat_nxt;
  logic          first_q, first_nxt;
  logic          init, col_step, row_step, res_step;
  logic          mul_rst_nxt, acc_clear_nxt, read_nxt, busy_nxt, done_nxt;
  logic          coeff4x_q;

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    beat_nxt  = beat_q;
    first_nxt = 1'b0;
    init      = 1'b0;
    col_step  = 1'b0;
    row_step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          init      = 1'b1;
          i_nxt     = '0;
          j_nxt     = '0;
          state_nxt = CLR;
        end
      end
      CLR: begin
        first_nxt = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        // The multiplier may still present a stale done while it leaves its idle state.
        if (!first_q && mul_done) begin
          if (j_q != IDX_LAST) begin
            j_nxt     = j_q + IDX_ONE;
            col_step  = 1'b1;
            state_nxt = MRST;
          end else begin
            beat_nxt  = '0;
            state_nxt = READ;
          end
        end
      end
      MRST: begin
        first_nxt = 1'b1;
        state_nxt = RUN;
      end
      READ: begin
        beat_nxt = beat_q + BEAT_ONE;
        if (beat_q == BEAT_LAST) begin
          if (i_q != IDX_LAST) begin
            i_nxt     = i_q + IDX_ONE;
            j_nxt     = '0;
            row_step  = 1'b1;
            state_nxt = CLR;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // MRST keeps the accumulator: restart without clear preserves the partial sum.
    mul_rst_nxt   = (state_nxt == IDLE) || (state_nxt == CLR) ||
                    (state_nxt == MRST) || (state_nxt == DONE);
    acc_clear_nxt = (state_nxt == CLR);
    read_nxt      = (state_nxt == READ);
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
  end

  assign res_step = (state == READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      beat_q        <= '0;
      first_q       <= 1'b0;
      mul_rst       <= 1'b1;
      mul_acc_clear <= 1'b0;
      mul_read      <= 1'b0;
      res_we        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      coeff4x_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      i_q           <= i_nxt;
      j_q           <= j_nxt;
      beat_q        <= beat_nxt;
      first_q       <= first_nxt;
      mul_rst       <= mul_rst_nxt;
      mul_acc_clear <= acc_clear_nxt;
      mul_read      <= read_nxt;
      res_we        <= read_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      if (init) begin
        coeff4x_q <= coeff4x;
      end
    end
  end

  assign mul_coeff4x = coeff4x_q;

  saber_matvec_addr_gen #(
    .L    (L),
    .AW   (AW),
    .POL_W(POL_WORDS),
    .SEC_W(SEC_WORDS)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .transpose(transpose),
    .a_base   (a_base),
    .s_base   (s_base),
    .r_base   (r_base),
    .col_step (col_step),
    .row_step (row_step),
    .res_step (res_step),
    .pol_addr (pol_addr_base),
    .sec_addr (sec_addr_base),
    .res_addr (res_addr)
  );

endmodule

// File: tb/tb_saber_matvec_sched.sv
// Randomized bench: behavioural multiplier plus matrix-level reference for the Saber scheduler.
// Checks control invariants every cycle, address/write order per run, and row data numerically.
module tb_saber_matvec_sched;

  localparam int L  = 3;
  localparam int AW = 10;
  localparam int PW = 52;
  localparam int SW = 16;
  localparam int RB = 64;
  localparam int N  = 256;
  localparam int Q  = 8192;

  logic          clk = 1'b0;
  logic          rst, start, transpose, coeff4x;
  logic [AW-1:0] a_base, s_base, r_base;
  logic          mul_rst, mul_acc_clear, mul_read, mul_coeff4x, mul_done;
  logic [AW-1:0] pol_addr_base, sec_addr_base, res_addr;
  logic          res_we, busy, done;

  always #5 clk = ~clk;

  saber_matvec_sched #(.L(L), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose(transpose), .coeff4x(coeff4x),
    .a_base(a_base), .s_base(s_base), .r_base(r_base),
    .mul_rst(mul_rst), .mul_acc_clear(mul_acc_clear), .mul_read(mul_read),
    .mul_coeff4x(mul_coeff4x), .mul_done(mul_done),
    .pol_addr_base(pol_addr_base), .sec_addr_base(sec_addr_base),
    .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Polynomial storage and behavioural multiplier state
  int a_poly[L*L][N];
  int s_poly[L][N];
  int acc[N];
  int res_mem[1024][4];
  int mcnt = 0, T_mul = 40, rd_ptr = 0;
  bit stale = 1'b0, prev_rst = 1'b1;
  assign mul_done = stale || (mcnt > T_mul);

  // Run bookkeeping
  logic [AW-1:0] run_a, run_s;
  logic [AW-1:0] q_pol[$], q_sec[$], q_res[$];
  int  rec_pol[$], rec_sec[$];
  bit  run_active = 1'b0, exp_c4x;
  int  cyc, exp_done, done_seen, done_cyc, n_clear, wr_cnt;
  int  first_wr, last_wr;

  function automatic int md(input int v);
    return ((v % Q) + Q) % Q;
  endfunction

  // Coefficient n of a*s in Z[x]/(x^256+1), unreduced.
  function automatic int conv_coef(input int ai, input int si, input int n);
    int sum = 0;
    for (int x = 0; x < N; x++) begin
      if (x <= n) sum += a_poly[ai][x] * s_poly[si][n-x];
      else        sum -= a_poly[ai][x] * s_poly[si][n-x+N];
    end
    return sum;
  endfunction

  function automatic int find_a(input logic [AW-1:0] addr);
    for (int k = 0; k < L*L; k++) if (AW'(run_a + k*PW) == addr) return k;
    return -1;
  endfunction

  function automatic int find_s(input logic [AW-1:0] addr);
    for (int k = 0; k < L; k++) if (AW'(run_s + k*SW) == addr) return k;
    return -1;
  endfunction

  task automatic model_and_check();
    int ai, si;
    if (mul_rst) mcnt = 0; else mcnt++;
    if (mul_acc_clear) begin
      for (int n = 0; n < N; n++) acc[n] = 0;
      rd_ptr = 0;
    end
    if (!mul_rst && prev_rst) begin
      ai = find_a(pol_addr_base);
      si = find_s(sec_addr_base);
      if (ai >= 0 && si >= 0)
        for (int n = 0; n < N; n++) acc[n] = md(acc[n] + conv_coef(ai, si, n));
    end
    if (mul_read) begin
      for (int k = 0; k < 4; k++) res_mem[res_addr][k] = acc[(4*rd_ptr + k) % N];
      rd_ptr++;
    end
    if (run_active) begin
      cyc++;
      chk("busy", busy, (cyc >= 1 && cyc <= exp_done));
      chk("done", done, (cyc == exp_done));
      if (done) begin done_seen++; done_cyc = cyc; end
      chk("we_vs_read", res_we, mul_read);
      if (mul_acc_clear) begin
        n_clear++;
        chk("clear_with_read", mul_read, 1'b0);
        chk("clear_with_rst", mul_rst, 1'b1);
      end
      if (mul_read) chk("read_not_done", mul_done, 1'b1);
      if (busy) chk("coeff4x_latch", mul_coeff4x, exp_c4x);
      else      chk("idle_mul_rst", mul_rst, 1'b1);
      if (!mul_rst && prev_rst) begin
        rec_pol.push_back(int'(pol_addr_base));
        rec_sec.push_back(int'(sec_addr_base));
        if (q_pol.size() == 0) chk("runs_left", q_pol.size(), 1);
        else begin
          chk("pol_addr", pol_addr_base, q_pol.pop_front());
          chk("sec_addr", sec_addr_base, q_sec.pop_front());
        end
      end
      if (res_we) begin
        if (wr_cnt == 0) first_wr = int'(res_addr);
        last_wr = int'(res_addr);
        wr_cnt++;
        if (q_res.size() == 0) chk("writes_left", q_res.size(), 1);
        else chk("res_addr", res_addr, q_res.pop_front());
      end
    end
    prev_rst = mul_rst;
  endtask

  always @(negedge clk) model_and_check();

  task automatic check_rows(input bit tr, input logic [AW-1:0] rb);
    int errs, v, idx;
    for (int i = 0; i < L; i++) begin
      errs = 0;
      for (int n = 0; n < N; n++) begin
        v = 0;
        for (int j = 0; j < L; j++) begin
          idx = tr ? j*L + i : i*L + j;
          v += conv_coef(idx, j, n);
        end
        if (res_mem[AW'(rb + i*RB + n/4)][n%4] != md(v)) errs++;
      end
      chk("row_data_errs", errs, 0);
    end
  endtask

  task automatic run_one(input bit tr, input bit c4, input logic [AW-1:0] ab, input logic [AW-1:0] sb,
                         input logic [AW-1:0] rb, input int t, input bit stl, input bit poke, input bit abort);
    int runlen;
    T_mul = t; stale = stl; run_a = ab; run_s = sb; exp_c4x = c4;
    for (int k = 0; k < L*L; k++) for (int n = 0; n < N; n++) a_poly[k][n] = $urandom_range(0, Q-1);
    for (int k = 0; k < L; k++)   for (int n = 0; n < N; n++) s_poly[k][n] = $urandom_range(0, 15);
    for (int a = 0; a < 1024; a++) for (int k = 0; k < 4; k++) res_mem[a][k] = -1;
    q_pol.delete(); q_sec.delete(); q_res.delete(); rec_pol.delete(); rec_sec.delete();
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < L; j++) begin
        q_pol.push_back(AW'(ab + (tr ? j*L + i : i*L + j) * PW));
        q_sec.push_back(AW'(sb + j*SW));
      end
      for (int b = 0; b < RB; b++) q_res.push_back(AW'(rb + i*RB + b));
    end
    runlen   = stl ? 2 : t + 1;
    exp_done = L * (1 + L*runlen + (L-1) + RB) + 1;
    n_clear = 0; wr_cnt = 0; done_seen = 0; done_cyc = 0; first_wr = -1; last_wr = -1;

    @(posedge clk); #1;
    transpose = tr; coeff4x = c4; a_base = ab; s_base = sb; r_base = rb; start = 1'b1;
    cyc = -1; run_active = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; transpose = ~tr; coeff4x = ~c4;
    a_base = AW'($urandom); s_base = AW'($urandom); r_base = AW'($urandom);
    if (poke) begin
      repeat (8) @(posedge clk);
      #1 start = 1'b1; transpose = ~tr; coeff4x = ~c4; a_base = AW'($urandom); s_base = AW'($urandom);
      @(posedge clk); #1 start = 1'b0;
    end
    if (abort) begin
      for (int k = 0; k < exp_done && wr_cnt < 20; k++) begin @(posedge clk); #1; end
      chk("abort_reached_beat20", wr_cnt, 20);
      rst = 1'b1; start = 1'b1; run_active = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_res_we", res_we, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_mul_rst", mul_rst, 1'b1);
      chk("abort_read", mul_read, 1'b0);
      chk("abort_clear", mul_acc_clear, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_pol", pol_addr_base, 0);
      chk("abort_res_addr", res_addr, 0);
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_beats_start", busy, 1'b0);
      chk("rst_beats_start_we", res_we, 1'b0);
      return;
    end
    for (int k = 0; k < exp_done + 20 && done_seen == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 run_active = 1'b0;
    chk("done_count", done_seen, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("pol_runs_left", q_pol.size(), 0);
    chk("res_writes_left", q_res.size(), 0);
    chk("clears_per_run", n_clear, L);
    chk("write_count", wr_cnt, L*RB);
    check_rows(tr, rb);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; transpose = 1'b0; coeff4x = 1'b0;
    a_base = '0; s_base = '0; r_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mul_rst", mul_rst, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_res_we", res_we, 1'b0);
    chk("rst_read", mul_read, 1'b0);
    chk("rst_clear", mul_acc_clear, 1'b0);
    chk("rst_c4x", mul_coeff4x, 1'b0);
    chk("rst_pol", pol_addr_base, 0);
    chk("rst_sec", sec_addr_base, 0);
    chk("rst_res_addr", res_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_rst", mul_rst, 1'b1);

    // Directed run, T_mul = 40: pinned address sequences and completion time.
    run_one(1'b0, 1'b0, 10'h000, 10'h200, 10'h300, 40, 1'b0, 1'b0, 1'b0);
    chk("lit_pol0", rec_pol[0], 0);
    chk("lit_pol1", rec_pol[1], 52);
    chk("lit_pol2", rec_pol[2], 104);
    chk("lit_pol3", rec_pol[3], 156);
    chk("lit_sec0", rec_sec[0], 'h200);
    chk("lit_sec1", rec_sec[1], 'h210);
    chk("lit_sec2", rec_sec[2], 'h220);
    chk("lit_first_wr", first_wr, 'h300);
    chk("lit_last_wr", last_wr, 'h3BF);
    chk("lit_done_cyc", done_cyc, 571);

    // Transposed walk.
    run_one(1'b1, 1'b1, 10'h000, AW'($urandom), AW'($urandom), $urandom_range(2, 30), 1'b0, 1'b0, 1'b0);
    chk("lit_tpol0", rec_pol[0], 0);
    chk("lit_tpol1", rec_pol[1], 156);
    chk("lit_tpol2", rec_pol[2], 312);
    chk("lit_tpol3", rec_pol[3], 52);
    chk("lit_tpol4", rec_pol[4], 208);
    chk("lit_tpol5", rec_pol[5], 364);

    // Random bases (including wrap-around) and timings.
    for (int r = 0; r < 2; r++)
      run_one(1'($urandom), 1'($urandom), AW'($urandom_range(700, 1023)), AW'($urandom), AW'($urandom),
              $urandom_range(1, 25), 1'b0, 1'b0, 1'b0);

    // start pulsed mid-run with different settings must be ignored.
    run_one(1'b0, 1'b1, AW'($urandom), AW'($urandom), AW'($urandom), 40, 1'b0, 1'b1, 1'b0);

    // Reset during READ beat 20, then a clean full run.
    run_one(1'b1, 1'b0, AW'($urandom), AW'($urandom), AW'($urandom), 12, 1'b0, 1'b0, 1'b1);
    run_one(1'b1, 1'b0, AW'($urandom), AW'($urandom), AW'($urandom), 12, 1'b0, 1'b0, 1'b0);

    // Stale mul_done held high: every RUN lasts exactly two cycles.
    run_one(1'b0, 1'b0, AW'($urandom), AW'($urandom), AW'($urandom), 40, 1'b1, 1'b0, 1'b0);
    chk("lit_stale_done_cyc", done_cyc, 220);
    chk("lit_stale_runs", rec_pol.size(), 9);
    stale = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
